// File: rtl/xibus_pkg.sv
// Shared XiBus types: master FSM states, transfer-mode/address-low encoding
// and the CPU write strobe to bus encoding used by master and slave checkers.
package xibus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   typedef struct packed {
      logic err;
      logic tm1n;
      logic tm0n;
      logic ad1n;
      logic ad0n;
   } tmad_t;

   localparam logic [1:0] TM_OK = 2'b00;

   // Illegal strobes keep the bus pins at their idle (deasserted) levels.
   function automatic tmad_t encode_strobe(input logic [3:0] strobe);
      tmad_t t;
      case (strobe)
         4'b0000: t = 5'b01111;
         4'b1111: t = 5'b00111;
         4'b0011: t = 5'b00110;
         4'b1100: t = 5'b00100;
         4'b0001: t = 5'b00011;
         4'b0010: t = 5'b00010;
         4'b0100: t = 5'b00001;
         4'b1000: t = 5'b00000;
         default: t = 5'b11111;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/xibus_tm_encoder.sv
// Combinational CPU write strobe -> {err, tm1n, tm0n, ad1n, ad0n} encoder.
module xibus_tm_encoder
   import xibus_pkg::*;
(
   input  logic [3:0] i_strobe,
   output logic [4:0] o_tmad
);

   assign o_tmad = encode_strobe(i_strobe);

endmodule

// File: rtl/xibus_master.sv
// XiBus master: turns a held CPU request into one address cycle plus data
// cycles on the multiplexed AD bus, with ack/timeout handling and status.
//
// state | meaning
// IDLE  | waiting for cpu_req, bus released
// ADDR  | address cycle, startn low, AD carries address
// DATA  | waiting for slave ackn, timeout counter running
// RESP  | one-cycle cpu_ack/cpu_error pulse, bus released
module xibus_master
   import xibus_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255,
   parameter int TO_W        = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic [3:0]        i_cpu_write,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [31:0]       i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [31:0]       o_cpu_rdata,
   output logic              o_cpu_error,
   output logic              o_cpu_busy,
   output logic              o_bus_startn,
   output logic [31:0]       o_bus_ad_o,
   output logic              o_bus_ad_oe,
   output logic              o_bus_tm1n_o,
   output logic              o_bus_tm0n_o,
   input  logic [31:0]       i_bus_ad_i,
   input  logic              i_bus_ackn_i,
   input  logic [1:0]        i_bus_tm_i
);

   logic [4:0]      w_tmad_raw;
   tmad_t           w_tmad;
   logic            w_data_done;
   logic            w_unused_addr;

   state_t          r_state;
   logic [TO_W-1:0] r_cnt;
   logic            r_is_write;
   logic [31:0]     r_wdata;
   logic            r_cpu_ack;
   logic [31:0]     r_cpu_rdata;
   logic            r_cpu_error;
   logic            r_cpu_busy;
   logic            r_bus_startn;
   logic [31:0]     r_bus_ad_o;
   logic            r_bus_ad_oe;
   logic            r_bus_tm1n;
   logic            r_bus_tm0n;

   xibus_tm_encoder u_tm_encoder (
      .i_strobe (i_cpu_write),
      .o_tmad   (w_tmad_raw)
   );

   assign w_tmad = tmad_t'(w_tmad_raw);

   // Only word-address bits reach AD; the low two come from the strobe encoding.
   assign w_unused_addr = ^i_cpu_addr;

   // Ack takes priority; the timeout fires on the cycle the counter would hit 0.
   assign w_data_done = !i_bus_ackn_i || (r_cnt <= TO_W'(1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_is_write   <= 1'b0;
         r_wdata      <= '0;
         r_cpu_ack    <= 1'b0;
         r_cpu_rdata  <= '0;
         r_cpu_error  <= 1'b0;
         r_cpu_busy   <= 1'b0;
         r_bus_startn <= 1'b1;
         r_bus_ad_o   <= '0;
         r_bus_ad_oe  <= 1'b0;
         r_bus_tm1n   <= 1'b1;
         r_bus_tm0n   <= 1'b1;
      end else begin
         r_cpu_ack   <= 1'b0;
         r_cpu_error <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_cpu_req) begin
                  r_cpu_busy <= 1'b1;
                  r_is_write <= |i_cpu_write;
                  r_wdata    <= i_cpu_wdata;
                  if (w_tmad.err) begin
                     r_state     <= ST_RESP;
                     r_cpu_ack   <= 1'b1;
                     r_cpu_error <= 1'b1;
                  end else begin
                     r_state      <= ST_ADDR;
                     r_bus_startn <= 1'b0;
                     r_bus_ad_oe  <= 1'b1;
                     r_bus_ad_o   <= {i_cpu_addr[31:2], ~w_tmad.ad1n, ~w_tmad.ad0n};
                     r_bus_tm1n   <= w_tmad.tm1n;
                     r_bus_tm0n   <= w_tmad.tm0n;
                  end
               end
            end
            ST_ADDR: begin
               r_state      <= ST_DATA;
               r_bus_startn <= 1'b1;
               r_cnt        <= TO_W'(TIMEOUT_CYC);
               r_bus_ad_oe  <= r_is_write;
               r_bus_ad_o   <= r_is_write ? r_wdata : 32'h0;
            end
            ST_DATA: begin
               if (i_bus_ackn_i) begin
                  r_cnt <= r_cnt - TO_W'(1);
               end else if (!r_is_write) begin
                  r_cpu_rdata <= i_bus_ad_i;
               end
               if (w_data_done) begin
                  r_state     <= ST_RESP;
                  r_cpu_ack   <= 1'b1;
                  r_cpu_error <= i_bus_ackn_i || (i_bus_tm_i != TM_OK);
                  r_bus_ad_oe <= 1'b0;
                  r_bus_ad_o  <= '0;
                  r_bus_tm1n  <= 1'b1;
                  r_bus_tm0n  <= 1'b1;
               end
            end
            ST_RESP: begin
               r_state    <= ST_IDLE;
               r_cpu_busy <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_cpu_ack    = r_cpu_ack;
   assign o_cpu_rdata  = r_cpu_rdata;
   assign o_cpu_error  = r_cpu_error;
   assign o_cpu_busy   = r_cpu_busy;
   assign o_bus_startn = r_bus_startn;
   assign o_bus_ad_o   = r_bus_ad_o;
   assign o_bus_ad_oe  = r_bus_ad_oe;
   assign o_bus_tm1n_o = r_bus_tm1n;
   assign o_bus_tm0n_o = r_bus_tm0n;

endmodule

// File: tb/tb_xibus_master.sv
// Directed bench for xibus_master: a transaction-level model expands each
// request into the per-cycle outputs expected; one process compares every cycle.
module tb_xibus_master;

   localparam int TO = 4;

   typedef struct {
      logic        ack;
      logic        err;
      logic        busy;
      logic        startn;
      logic        oe;
      logic [31:0] ad;
      logic [1:0]  tmn;
      logic [31:0] rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [3:0]  cpu_write;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        cpu_error;
   logic        cpu_busy;
   logic        bus_startn;
   logic [31:0] bus_ad_o;
   logic        bus_ad_oe;
   logic        bus_tm1n;
   logic        bus_tm0n;
   logic [31:0] bus_ad_i;
   logic        bus_ackn;
   logic [1:0]  bus_tm_i;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   xibus_master #(.ADDR_W(32), .TIMEOUT_CYC(TO), .TO_W(8)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_cpu_req    (cpu_req),
      .i_cpu_write  (cpu_write),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wdata  (cpu_wdata),
      .o_cpu_ack    (cpu_ack),
      .o_cpu_rdata  (cpu_rdata),
      .o_cpu_error  (cpu_error),
      .o_cpu_busy   (cpu_busy),
      .o_bus_startn (bus_startn),
      .o_bus_ad_o   (bus_ad_o),
      .o_bus_ad_oe  (bus_ad_oe),
      .o_bus_tm1n_o (bus_tm1n),
      .o_bus_tm0n_o (bus_tm0n),
      .i_bus_ad_i   (bus_ad_i),
      .i_bus_ackn_i (bus_ackn),
      .i_bus_tm_i   (bus_tm_i)
   );

   exp_t        exp_q[$];
   logic [31:0] mrd;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          ack_cyc  = -1;
   logic        ack_err;
   logic [31:0] ack_rdata;
   logic [31:0] addr_ad;

   function automatic exp_t mk(input logic ack, input logic err, input logic busy,
                               input logic startn, input logic oe, input logic [31:0] ad,
                               input logic [1:0] tmn, input logic [31:0] rd);
      exp_t e;
      e.ack = ack; e.err = err; e.busy = busy; e.startn = startn;
      e.oe = oe; e.ad = ad; e.tmn = tmn; e.rd = rd;
      return e;
   endfunction

   function automatic exp_t idle_v();
      return mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b11, mrd);
   endfunction

   // Strobe table: legality, transfer-mode pins, and the AD[1:0] value of the address cycle.
   task automatic tb_enc(input logic [3:0] s, output logic ok, output logic [1:0] tmn,
                         output logic [1:0] adlo);
      ok = 1'b1; tmn = 2'b00; adlo = 2'b00;
      case (s)
         4'b0000: tmn = 2'b11;
         4'b1111: tmn = 2'b01;
         4'b0011: begin tmn = 2'b01; adlo = 2'b01; end
         4'b1100: begin tmn = 2'b01; adlo = 2'b11; end
         4'b0001: adlo = 2'd0;
         4'b0010: adlo = 2'd1;
         4'b0100: adlo = 2'd2;
         4'b1000: adlo = 2'd3;
         default: ok = 1'b0;
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, want);
   endtask

   task automatic compare_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (cpu_ack === 1'b1) begin
            ack_cyc   = cyc;
            ack_err   = cpu_error;
            ack_rdata = cpu_rdata;
         end
         if (bus_startn === 1'b0) addr_ad = bus_ad_o;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({cpu_ack, cpu_error, cpu_busy, bus_startn, bus_ad_oe, bus_ad_o, bus_tm1n, bus_tm0n, cpu_rdata}
                === {e.ack, e.err, e.busy, e.startn, e.oe, e.ad, e.tmn, e.rd})
               n_pass++;
            else
               $display("FAIL cycle %0d outputs: got ack=%b err=%b busy=%b startn=%b oe=%b ad=%h tmn=%b%b rdata=%h, want ack=%b err=%b busy=%b startn=%b oe=%b ad=%h tmn=%b rdata=%h",
                        cyc, cpu_ack, cpu_error, cpu_busy, bus_startn, bus_ad_oe, bus_ad_o, bus_tm1n, bus_tm0n, cpu_rdata,
                        e.ack, e.err, e.busy, e.startn, e.oe, e.ad, e.tmn, e.rd);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(idle_v());
         step();
      end
   endtask

   // waits < 0: slave never acknowledges. drop: release cpu_req after the address cycle.
   task automatic xfer(input logic [3:0] stb, input logic [31:0] addr, input logic [31:0] wdata,
                       input int waits, input logic [31:0] adi, input logic [1:0] tmi, input bit drop,
                       input int lat_lit, input logic [31:0] ad_lit, input logic err_lit,
                       input logic [31:0] rd_lit);
      logic       ok;
      logic [1:0] tmn;
      logic [1:0] adlo;
      logic       wr;
      logic       err;
      bit         acked;
      int         k;
      int         s;
      tb_enc(stb, ok, tmn, adlo);
      wr    = (stb != 4'b0000);
      acked = (waits >= 0) && (waits < TO);
      k     = acked ? waits + 1 : TO;
      exp_q.push_back(idle_v());
      cpu_req = 1'b1; cpu_write = stb; cpu_addr = addr; cpu_wdata = wdata;
      step();
      s = cyc;
      if (!ok) begin
         exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2'b11, mrd));
      end else begin
         exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, {addr[31:2], adlo}, tmn, mrd));
         if (drop) cpu_req = 1'b0;
         for (int d = 1; d <= k; d++) begin
            step();
            bus_ackn = !(acked && d == k);
            bus_ad_i = (acked && d == k) ? adi : ~adi;
            bus_tm_i = (d == k) ? tmi : 2'b11;
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, wr, wr ? wdata : 32'h0, tmn, mrd));
         end
         step();
         bus_ackn = 1'b1; bus_ad_i = 32'h0; bus_tm_i = 2'b00;
         err = acked ? (tmi != 2'b00) : 1'b1;
         if (acked && !wr) mrd = adi;
         exp_q.push_back(mk(1'b1, err, 1'b1, 1'b1, 1'b0, 32'h0, 2'b11, mrd));
      end
      step();
      cpu_req = 1'b0; cpu_write = 4'b0000;
      chk("ack_latency", 32'(ack_cyc + 1 - s), 32'(lat_lit));
      if (ok) chk("addr_cycle_ad", addr_ad, ad_lit);
      chk("ack_error", {31'h0, ack_err}, {31'h0, err_lit});
      chk("ack_rdata", ack_rdata, rd_lit);
   endtask

   task automatic reset_mid();
      int s;
      exp_q.push_back(idle_v());
      cpu_req = 1'b1; cpu_write = 4'b1111; cpu_addr = 32'h0000_0050; cpu_wdata = 32'h0000_0077;
      step();
      s = cyc;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0050, 2'b01, mrd));
      step();
      bus_ackn = 1'b1;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0077, 2'b01, mrd));
      rst = 1'b1;
      step();
      rst = 1'b0; cpu_req = 1'b0; cpu_write = 4'b0000;
      mrd = 32'h0;
      chk("no_ack_after_reset", {31'h0, ack_cyc < s}, 32'h1);
      chk("reset_startn", {31'h0, bus_startn}, 32'h1);
      chk("reset_oe", {31'h0, bus_ad_oe}, 32'h0);
   endtask

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_write = 4'b0000; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      bus_ad_i = 32'h0; bus_ackn = 1'b1; bus_tm_i = 2'b00; mrd = 32'h0;
      fork
         compare_loop();
      join_none
      step();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(idle_v());
         step();
      end
      chk("reset_busy", {31'h0, cpu_busy}, 32'h0);
      chk("reset_tm", {30'h0, bus_tm1n, bus_tm0n}, 32'h3);
      rst = 1'b0;
      idle(2);

      xfer(4'b0000, 32'h1234_5678, 32'h0, 0, 32'hCAFE_F00D, 2'b00, 1'b0,
           3, 32'h1234_5678, 1'b0, 32'hCAFE_F00D);
      idle(1);
      xfer(4'b0100, 32'h0000_1000, 32'h00AB_0000, 2, 32'h5555_AAAA, 2'b00, 1'b0,
           5, 32'h0000_1002, 1'b0, 32'hCAFE_F00D);
      xfer(4'b0101, 32'h0000_2000, 32'h0000_0001, 0, 32'h0, 2'b00, 1'b0,
           1, 32'h0, 1'b1, 32'hCAFE_F00D);
      xfer(4'b0000, 32'h8000_0004, 32'h0, -1, 32'h1357_9BDF, 2'b00, 1'b0,
           6, 32'h8000_0004, 1'b1, 32'hCAFE_F00D);
      xfer(4'b1111, 32'h2000_0010, 32'hDEAD_BEEF, 1, 32'h2468_ACE0, 2'b10, 1'b0,
           4, 32'h2000_0010, 1'b1, 32'hCAFE_F00D);
      xfer(4'b1100, 32'h0000_0040, 32'h1234_0000, 0, 32'h9999_9999, 2'b00, 1'b0,
           3, 32'h0000_0043, 1'b0, 32'hCAFE_F00D);
      xfer(4'b0000, 32'h3000_0008, 32'h0, 3, 32'h0BAD_F00D, 2'b00, 1'b1,
           6, 32'h3000_0008, 1'b0, 32'h0BAD_F00D);
      idle(1);
      xfer(4'b0011, 32'h0000_0100, 32'h0000_BEEF, 0, 32'h7777_0000, 2'b01, 1'b0,
           3, 32'h0000_0101, 1'b1, 32'h0BAD_F00D);
      xfer(4'b1000, 32'h0000_0200, 32'hAB00_0000, 0, 32'h0, 2'b00, 1'b0,
           3, 32'h0000_0203, 1'b0, 32'h0BAD_F00D);
      xfer(4'b0010, 32'h0000_0204, 32'h0000_CD00, 1, 32'h0, 2'b00, 1'b0,
           4, 32'h0000_0205, 1'b0, 32'h0BAD_F00D);
      xfer(4'b0001, 32'h0000_0208, 32'h0000_0012, 0, 32'h0, 2'b00, 1'b0,
           3, 32'h0000_0208, 1'b0, 32'h0BAD_F00D);
      xfer(4'b1110, 32'h0000_0300, 32'h0, 0, 32'h0, 2'b00, 1'b0,
           1, 32'h0, 1'b1, 32'h0BAD_F00D);
      idle(1);
      reset_mid();
      xfer(4'b0000, 32'h0000_0004, 32'h0, 0, 32'h1111_2222, 2'b00, 1'b0,
           3, 32'h0000_0004, 1'b0, 32'h1111_2222);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
